// File: rtl/ext_pkg.sv
// Shared op codes and sizing helpers for the extension pipeline.
package ext_pkg;

    localparam logic [2:0] OP_SIGN = 3'd0;
    localparam logic [2:0] OP_ZERO = 3'd1;
    localparam logic [2:0] OP_LUI  = 3'd2;
    localparam logic [2:0] OP_LB   = 3'd3;
    localparam logic [2:0] OP_LBU  = 3'd4;
    localparam logic [2:0] OP_LH   = 3'd5;
    localparam logic [2:0] OP_LHU  = 3'd6;
    localparam logic [2:0] OP_LW   = 3'd7;

    // Width of the byte offset within one datapath word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Producer/consumer handshake bundle for ext_pipe; the slave modport is the block side.
interface ext_pipe_if
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 2
);
    localparam int OFF_W = off_w(DATA_W);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [IMM_W-1:0]  in_imm;
    logic [DATA_W-1:0] in_word;
    logic [OFF_W-1:0]  in_addr_lo;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_adel;
    logic [LVL_W-1:0]  level;

    modport master (
        output flush, in_valid, in_op, in_imm, in_word, in_addr_lo, out_ready,
        input  in_ready, out_valid, out_data, out_adel, level
    );

    modport slave (
        input  flush, in_valid, in_op, in_imm, in_word, in_addr_lo, out_ready,
        output in_ready, out_valid, out_data, out_adel, level
    );

endinterface

// File: rtl/ext_core.sv
// Combinational immediate / load-data extension with misaligned-load detection.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = off_w(DATA_W)
) (
    input  logic [2:0]        in_op,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_word,
    input  logic [OFF_W-1:0]  in_addr_lo,
    output logic [DATA_W-1:0] result,
    output logic              adel
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword index drops the low offset bit so the select never runs off the word.
    always_comb begin
        byte_v = in_word[{in_addr_lo, 3'b000} +: 8];
        half_v = in_word[{in_addr_lo[OFF_W-1:1], 4'b0000} +: 16];
    end

    always_comb begin
        result = '0;
        adel   = 1'b0;
        case (in_op)
            OP_SIGN: result = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
            OP_ZERO: result = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            OP_LUI:  result = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            OP_LB:   result = {{(DATA_W-8){byte_v[7]}}, byte_v};
            OP_LBU:  result = {{(DATA_W-8){1'b0}}, byte_v};
            OP_LH: begin
                if (in_addr_lo[0]) adel = 1'b1;
                else               result = {{(DATA_W-16){half_v[15]}}, half_v};
            end
            OP_LHU: begin
                if (in_addr_lo[0]) adel = 1'b1;
                else               result = {{(DATA_W-16){1'b0}}, half_v};
            end
            OP_LW: begin
                if (in_addr_lo != '0) adel = 1'b1;
                else                  result = in_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Extension unit feeding a DEPTH-entry FIFO with valid/ready on both sides.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 2
) (
    input logic       clk,
    input logic       reset,
    ext_pipe_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              adel;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic [DATA_W-1:0] core_data;
    logic              core_adel;
    logic              push;
    logic              pop;
    logic              out_valid;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .in_op      (bus.in_op),
        .in_imm     (bus.in_imm),
        .in_word    (bus.in_word),
        .in_addr_lo (bus.in_addr_lo),
        .result     (core_data),
        .adel       (core_adel)
    );

    // A full FIFO may still accept when the consumer drains the head this cycle.
    always_comb begin
        out_valid    = (level_q != '0);
        bus.in_ready = reset && ((level_q < LVL_W'(DEPTH)) || bus.out_ready);
        push         = bus.in_valid && bus.in_ready;
        pop          = out_valid && bus.out_ready;
    end

    always_comb begin
        bus.out_valid = out_valid;
        bus.out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
        bus.out_adel  = out_valid ? mem_q[rd_ptr_q].adel : 1'b0;
        bus.level     = level_q;
    end

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{data: core_data, adel: core_adel};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed, table-driven bench for ext_pipe with DATA_W=32, IMM_W=16, DEPTH=2.
module tb_ext_pipe;
    import ext_pkg::*;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int DEPTH  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ext_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) bus ();

    ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] imm;
        logic [31:0] word;
        logic [1:0]  addr;
        logic [31:0] exp_data;
        logic        exp_adel;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic valid, input logic [2:0] op, input logic [15:0] imm,
                              input logic [31:0] word, input logic [1:0] addr);
        bus.in_valid   = valid;
        bus.in_op      = op;
        bus.in_imm     = imm;
        bus.in_word    = word;
        bus.in_addr_lo = addr;
    endtask

    // Drive one op at the falling edge, let the rising edge take it, sample 1 time unit later.
    task automatic apply_stimulus(input logic [2:0] op, input logic [15:0] imm,
                                  input logic [31:0] word, input logic [1:0] addr);
        @(negedge clk);
        set_inputs(1'b1, op, imm, word, addr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{"zero_8001", OP_ZERO, 16'h8001, 32'hDEAD_BEEF, 2'd3, 32'h0000_8001, 1'b0});
        vecs.push_back('{"lui_8001",  OP_LUI,  16'h8001, 32'h1234_5678, 2'd1, 32'h8001_0000, 1'b0});
        vecs.push_back('{"sign_7fff", OP_SIGN, 16'h7FFF, 32'hFFFF_FFFF, 2'd2, 32'h0000_7FFF, 1'b0});
        vecs.push_back('{"lb_off0",   OP_LB,   16'hFFFF, 32'h80FF_7F01, 2'd0, 32'h0000_0001, 1'b0});
        vecs.push_back('{"lb_off1",   OP_LB,   16'h0000, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0});
        vecs.push_back('{"lb_off2",   OP_LB,   16'h0000, 32'h80FF_7F01, 2'd2, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"lb_off3",   OP_LB,   16'h0000, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{"lbu_off2",  OP_LBU,  16'h0000, 32'h80FF_7F01, 2'd2, 32'h0000_00FF, 1'b0});
        vecs.push_back('{"lbu_off3",  OP_LBU,  16'h0000, 32'h80FF_7F01, 2'd3, 32'h0000_0080, 1'b0});
        vecs.push_back('{"lh_off0",   OP_LH,   16'h0000, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0});
        vecs.push_back('{"lh_off2",   OP_LH,   16'h0000, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0});
        vecs.push_back('{"lhu_off2",  OP_LHU,  16'h0000, 32'h80FF_7F01, 2'd2, 32'h0000_80FF, 1'b0});
        vecs.push_back('{"lhu_off0",  OP_LHU,  16'h0000, 32'h80FF_8F01, 2'd0, 32'h0000_8F01, 1'b0});
        vecs.push_back('{"lh_off1",   OP_LH,   16'h0000, 32'h80FF_7F01, 2'd1, 32'h0000_0000, 1'b1});
        vecs.push_back('{"lw_off2",   OP_LW,   16'h0000, 32'h80FF_7F01, 2'd2, 32'h0000_0000, 1'b1});
        vecs.push_back('{"lw_off0",   OP_LW,   16'h0000, 32'h80FF_7F01, 2'd0, 32'h80FF_7F01, 1'b0});
        vecs.push_back('{"lhu_off3",  OP_LHU,  16'h0000, 32'h80FF_7F01, 2'd3, 32'h0000_0000, 1'b1});
        vecs.push_back('{"lw_off1",   OP_LW,   16'h0000, 32'h1111_2222, 2'd1, 32'h0000_0000, 1'b1});

        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        set_inputs(1'b1, OP_SIGN, 16'h8001, 32'h0, 2'd0);

        // Held in reset with a valid op offered.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("rst_out_data",  64'(bus.out_data),  64'd0);
        check_output("rst_level",     64'(bus.level),     64'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rel_in_ready", 64'(bus.in_ready), 64'd1);
        apply_stimulus(OP_SIGN, 16'h8001, 32'h0, 2'd0);
        check_output("first_valid", 64'(bus.out_valid), 64'd1);
        check_output("first_data",  64'(bus.out_data),  64'hFFFF_8001);
        check_output("first_level", 64'(bus.level),     64'd1);

        // Streaming: each push also pops the previous head, so level stays at 1.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].imm, vecs[i].word, vecs[i].addr);
            check_output({vecs[i].name, "_valid"}, 64'(bus.out_valid), 64'd1);
            check_output({vecs[i].name, "_data"},  64'(bus.out_data),  64'(vecs[i].exp_data));
            check_output({vecs[i].name, "_adel"},  64'(bus.out_adel),  64'(vecs[i].exp_adel));
            check_output({vecs[i].name, "_level"}, 64'(bus.level),     64'd1);
        end

        idle_cycle();
        check_output("drain_valid", 64'(bus.out_valid), 64'd0);
        check_output("drain_data",  64'(bus.out_data),  64'd0);
        check_output("drain_adel",  64'(bus.out_adel),  64'd0);
        check_output("drain_level", 64'(bus.level),     64'd0);

        // Fill with the consumer stalled, then release it while pushing.
        @(negedge clk);
        bus.out_ready = 1'b0;
        apply_stimulus(OP_ZERO, 16'h0001, 32'h0, 2'd0);
        check_output("fill1_level", 64'(bus.level), 64'd1);
        apply_stimulus(OP_ZERO, 16'h0002, 32'h0, 2'd0);
        check_output("fill2_level", 64'(bus.level), 64'd2);
        @(negedge clk);
        set_inputs(1'b1, OP_ZERO, 16'h0003, 32'h0, 2'd0);
        #1;
        check_output("full_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check_output("stall_level", 64'(bus.level),    64'd2);
        check_output("stall_head",  64'(bus.out_data), 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check_output("full_pop_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_output("pushpop_level", 64'(bus.level),    64'd2);
        check_output("pushpop_head",  64'(bus.out_data), 64'd2);
        idle_cycle();
        check_output("order_head3", 64'(bus.out_data), 64'd3);
        check_output("order_level", 64'(bus.level),    64'd1);
        idle_cycle();
        check_output("order_empty", 64'(bus.out_valid), 64'd0);

        // Flush with a push and pop offered in the same cycle.
        @(negedge clk);
        bus.out_ready = 1'b0;
        apply_stimulus(OP_ZERO, 16'h00AA, 32'h0, 2'd0);
        apply_stimulus(OP_ZERO, 16'h00BB, 32'h0, 2'd0);
        check_output("preflush_level", 64'(bus.level), 64'd2);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        set_inputs(1'b1, OP_ZERO, 16'h00DD, 32'h0, 2'd0);
        #1;
        check_output("flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_output("flush_level", 64'(bus.level),     64'd0);
        check_output("flush_valid", 64'(bus.out_valid), 64'd0);
        check_output("flush_data",  64'(bus.out_data),  64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("postflush_valid", 64'(bus.out_valid), 64'd0);
        apply_stimulus(OP_ZERO, 16'h00EE, 32'h0, 2'd0);
        check_output("postflush_data", 64'(bus.out_data), 64'h0000_00EE);

        // Asynchronous reset between clock edges drops the buffered entry.
        @(negedge clk);
        bus.out_ready = 1'b0;
        apply_stimulus(OP_ZERO, 16'h0077, 32'h0, 2'd0);
        check_output("prerst_level", 64'(bus.level), 64'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_output("async_rst_valid",    64'(bus.out_valid), 64'd0);
        check_output("async_rst_level",    64'(bus.level),     64'd0);
        check_output("async_rst_in_ready", 64'(bus.in_ready),  64'd0);
        #1 reset = 1'b1;
        bus.out_ready = 1'b1;
        apply_stimulus(OP_LUI, 16'h1234, 32'h0, 2'd0);
        check_output("after_rst_valid", 64'(bus.out_valid), 64'd1);
        check_output("after_rst_data",  64'(bus.out_data),  64'h1234_0000);
        idle_cycle();
        check_output("final_level", 64'(bus.level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, buffered extension unit for the pipelined MIPS datapath. Combines immediate extension (sign, zero, LUI) and load-data extension (lb/lbu/lh/lhu/lw byte-lane select plus extension) in one block. Results go through a DEPTH-entry FIFO with valid/ready handshakes on both sides. The block sits between the decode/memory stage producers and the consumers that can stall, and flags misaligned loads for the exception path.

## Interface
- DATA_W, 32: datapath width. Must be a multiple of 16, and 32 or 64.
- IMM_W, 16: immediate width. Must be less than DATA_W.
- DEPTH, 2: FIFO entries. Must be a power of two, at least 2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  producer has an operation.
- in_ready  out  1  block accepts this cycle.
- in_op  in  3  operation code; see Operation.
- in_imm  in  IMM_W  immediate source.
- in_word  in  DATA_W  memory word source.
- in_addr_lo  in  log2(DATA_W/8)  byte offset of the load address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_data  out  DATA_W  extended result.
- out_adel  out  1  misaligned-load flag for the head entry.
- level  out  log2(DEPTH)+1  current occupancy.

## Operation
- Op codes:
  - 0 SIGN: in_imm sign-extended to DATA_W.
  - 1 ZERO: in_imm zero-extended.
  - 2 LUI: in_imm placed at the top, {in_imm, (DATA_W-IMM_W) zeros}.
  - 3 LB: byte at in_addr_lo, sign-extended.
  - 4 LBU: byte at in_addr_lo, zero-extended.
  - 5 LH: halfword at in_addr_lo, sign-extended.
  - 6 LHU: halfword at in_addr_lo, zero-extended.
  - 7 LW: full DATA_W word.
- Byte lanes are little-endian: byte k = in_word[8k+7:8k]; halfword at offset k = in_word[8k+15:8k].
- Ops 0–2 ignore in_word and in_addr_lo. Ops 3–7 ignore in_imm.
- Misalignment:
  - LH/LHU with in_addr_lo[0]=1 is misaligned.
  - LW with in_addr_lo≠0 is misaligned.
  - A misaligned entry is stored with data 0 and adel 1. It still occupies a slot and is delivered in order.
- Push: in_valid && in_ready.
- Pop: out_valid && out_ready.
- in_ready = reset && (level<DEPTH || out_ready). When full, a simultaneous push and pop is allowed and level stays at DEPTH.
- Order is strict FIFO. Read and write pointers wrap modulo DEPTH.
- When out_valid=0, out_data and out_adel are driven 0.
- flush=1 at a clock edge: level→0, both pointers→0, and any same-cycle push or pop is ignored. in_ready still follows its formula during the flush cycle.

## Timing
- Reset values: out_valid 0, out_data 0, out_adel 0, level 0, in_ready 0 while reset=0. Pointers are 0.
- Reset asserted mid-operation drops all entries asynchronously. The first push is accepted on the first edge after reset rises.
- Latency: a push at edge N gives out_valid=1 with that result after edge N. There is no same-cycle bypass from input to output.
- Throughput is one op per cycle sustained while out_ready=1. With out_ready=0, DEPTH pushes fill the FIFO and in_ready then drops the same cycle.
- Empty with a push and pop in the same cycle: the pop is not possible (out_valid=0); only the push takes effect.
- Extension logic is combinational before the FIFO write. FIFO outputs are read from registered storage, with the valid mask applied combinationally.

## Structure
- Package ext_pkg holds:
  - the op-code localparams (OP_SIGN … OP_LW, 3 bits);
  - a helper computing the offset width, log2(DATA_W/8).
- Sub-module ext_core is purely combinational. It takes in_op, in_imm, in_word and in_addr_lo and produces the result and adel. It is parametrised by DATA_W and IMM_W.
- The ext_pipe top level instantiates ext_core and contains the FIFO storage, pointers, level counter and handshake logic.

## Test plan
- Reset low for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_data=0. After release: op 0, imm 0x8001 → out_data 0xFFFF8001 one cycle later.
- Ops 1 and 2, imm 0x8001 → 0x00008001 and 0x80010000. With DATA_W=64, op 2 gives 0x0000000080010000's counterpart {imm, 48 zeros}.
- in_word 0x80FF7F01, op LB at offsets 0–3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LHU at offset 2 → 0x000080FF.
- LH at offset 1 and LW at offset 2 → out_adel=1, out_data=0. The following aligned LW delivers in_word with adel=0, in order.
- out_ready=0, push 3 ops with DEPTH=2 → third push stalled (in_ready=0), level=2. Then out_ready=1 with a push in the same cycle → level stays 2 and order is preserved.
- Two entries buffered, assert flush together with a push → level=0 next cycle, out_valid=0, and the pushed op is never delivered.
